if_id_skid_buffer: RTL and testbench
====================================

# if_id_skid_buffer

Parametrised IF/ID pipeline stage between instruction fetch and decode. It carries opcode, operand fields and PC under a valid/ready handshake, with a two-entry skid so the upstream ready is registered. It adds a decode-side hold, a flush that squashes both entries into bubbles, and an occupancy count for hazard logic.

## Interface
- PC_W, 16, PC width
- OPC_W, 4, opcode width
- FLD_W, 4, width of one operand field
- NUM_FLD, 3, number of operand fields
- NOP_OPCODE, 0, opcode presented on a bubble

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer can accept; registered, equals !skid_valid
- in_opcode  in  OPC_W  fetched opcode
- in_fields  in  NUM_FLD*FLD_W  operand fields, field 0 in LSBs
- in_pc  in  PC_W  fetch PC
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode can consume
- hazard  in  1  hold: decode-side entry does not advance
- flush  in  1  squash all held and incoming instructions
- out_opcode  out  OPC_W  NOP_OPCODE when out_valid=0
- out_fields  out  NUM_FLD*FLD_W  decode-side fields
- out_pc  out  PC_W  decode-side PC
- occupancy  out  2  entries held, 0..2

## Operation
- Two slots: main (drives out_*) and skid. Each holds valid, opcode, fields, pc.
- accept = in_valid & in_ready; pop = out_valid & out_ready & !hazard.
- Priority each cycle: reset > flush > normal update.
- reset: both valids 0; all payload regs 0; opcode regs NOP_OPCODE. Outputs while and after reset: in_ready=1, out_valid=0, out_opcode=NOP_OPCODE, out_fields=0, out_pc=0, occupancy=0.
- flush (reset low): both valids 0 next cycle. A same-cycle accept is dropped. Payload regs keep their values. hazard and out_ready are ignored.
- Normal update:
  - main empty, accept: main <= input.
  - main valid, pop, skid empty: main <= input if accept, else main_valid <= 0.
  - main valid, no pop, accept: skid <= input. Only possible when skid is empty.
  - main valid, pop, skid valid: main <= skid, skid_valid <= 0. No accept is possible because in_ready=0.
  - Otherwise hold.
- Order is preserved; no instruction is duplicated or lost except by flush.
- Bubble masking: out_opcode is combinationally NOP_OPCODE whenever main_valid=0. Fields and pc show the held register values.
- occupancy = main_valid + skid_valid, registered-derived with no combinational input path.
- Invariant: skid_valid implies main_valid. Must be asserted in the bench.

## Timing
- Latency: an instruction accepted at edge N is visible on out_* after edge N while the buffer is empty.
- Throughput: 1 instruction/cycle while pop is continuous; in_ready stays 1.
- A single-cycle stall (pop=0 with main valid) fills the skid. in_ready drops after that edge and returns 1 the cycle after the next pop.
- No combinational path from out_ready, hazard or flush to in_ready.
- out_* depend combinationally only on registers.
- flush asserted at edge N: out_valid=0, out_opcode=NOP_OPCODE and in_ready=1 after edge N. A new accept is possible in cycle N+1.
- flush and reset held multiple cycles: state stays empty.

## Structure
- Shared package ifid_pkg: NOP_OPCODE default, default PC_W/OPC_W/FLD_W/NUM_FLD constants, and an entry struct {valid, opcode, fields, pc}.
- One sub-module, ifid_slot: a payload register with valid, load, clear and synchronous reset, instantiated twice (main, skid).
- Top level holds accept/pop/steering logic only.

## Test plan
- Reset: assert reset 2 cycles during in_valid=1 with opcode 0xA -> out_valid=0, out_opcode=0x0, out_pc=0, in_ready=1, occupancy=0 throughout; first accept after release appears next cycle.
- Streaming: out_ready=1, hazard=0, feed PC 0x0100..0x0107 back-to-back -> each appears one cycle later in order; in_ready never drops; occupancy=1.
- Skid: hazard=1 for one cycle while PC 0x0200 in main and 0x0201 arriving -> occupancy=2, in_ready=0 next cycle. Then 0x0200 and 0x0201 emerge on consecutive cycles, and in_ready=1 one cycle after the first pop.
- Flush with full buffer: occupancy=2, flush=1 with in_valid=1 (PC 0x0300) -> next cycle out_valid=0, out_opcode=NOP_OPCODE, occupancy=0, and 0x0300 never appears.
- Simultaneous: flush=1 and hazard=1 -> flush wins, buffer empties. Then pop and accept in the same cycle with the skid empty -> main replaced, occupancy stays 1.
- Randomised backpressure on out_ready/hazard, 10k cycles -> scoreboard order matches, skid_valid implies main_valid always holds, no loss without flush.

Source files
------------

// File: rtl/if_id_skid_buffer_pkg.sv
// Shared defaults for the IF/ID skid buffer: field widths, bubble opcode and
// the default-width entry record used by anything outside the parametrised core.
package ifid_pkg;

    localparam int unsigned DEF_PC_W    = 16;
    localparam int unsigned DEF_OPC_W   = 4;
    localparam int unsigned DEF_FLD_W   = 4;
    localparam int unsigned DEF_NUM_FLD = 3;

    localparam logic [DEF_OPC_W-1:0] DEF_NOP_OPCODE = '0;

    typedef struct packed {
        logic                               valid;
        logic [DEF_OPC_W-1:0]               opcode;
        logic [DEF_NUM_FLD*DEF_FLD_W-1:0]   fields;
        logic [DEF_PC_W-1:0]                pc;
    } entry_t;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// Fetch/decode handshake bundle; the buffer uses the slave view, the fetch
// and decode environment drives through the master view.
interface if_id_skid_buffer_if
    import ifid_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int FLD_W   = DEF_FLD_W,
    parameter int NUM_FLD = DEF_NUM_FLD
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [OPC_W-1:0]         in_opcode;
    logic [NUM_FLD*FLD_W-1:0] in_fields;
    logic [PC_W-1:0]          in_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic                     hazard;
    logic                     flush;
    logic [OPC_W-1:0]         out_opcode;
    logic [NUM_FLD*FLD_W-1:0] out_fields;
    logic [PC_W-1:0]          out_pc;
    logic [1:0]               occupancy;

    modport slave (
        input  in_valid, in_opcode, in_fields, in_pc, out_ready, hazard, flush,
        output in_ready, out_valid, out_opcode, out_fields, out_pc, occupancy
    );

    modport master (
        output in_valid, in_opcode, in_fields, in_pc, out_ready, hazard, flush,
        input  in_ready, out_valid, out_opcode, out_fields, out_pc, occupancy
    );

endinterface

// File: rtl/if_id_skid_buffer_slot.sv
// One buffer slot: a valid bit plus packed payload. Clear drops only the valid
// bit so a squashed slot still shows its last payload.
module ifid_slot #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Clear outranks load so a flush can never be overridden by steering.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline register with a two-entry skid so in_ready comes straight
// from a flop; adds decode hold, flush-to-bubble and an occupancy count.
module if_id_skid_buffer
    import ifid_pkg::*;
#(
    parameter int               PC_W       = DEF_PC_W,
    parameter int               OPC_W      = DEF_OPC_W,
    parameter int               FLD_W      = DEF_FLD_W,
    parameter int               NUM_FLD    = DEF_NUM_FLD,
    parameter logic [OPC_W-1:0] NOP_OPCODE = DEF_NOP_OPCODE
) (
    input logic                clk,
    input logic                reset,
    if_id_skid_buffer_if.slave bus
);

    localparam int FW    = NUM_FLD * FLD_W;
    localparam int PAY_W = OPC_W + FW + PC_W;
    localparam logic [PAY_W-1:0] PAY_RST = {NOP_OPCODE, {(FW + PC_W){1'b0}}};

    logic             main_valid, skid_valid;
    logic [PAY_W-1:0] main_pay, skid_pay, in_pay, main_d;
    logic             accept, pop;
    logic             main_load, main_clear, skid_load, skid_clear;

    assign in_pay = {bus.in_opcode, bus.in_fields, bus.in_pc};
    assign accept = bus.in_valid & ~skid_valid;
    assign pop    = main_valid & bus.out_ready & ~bus.hazard;

    // Main refills from the skid first to keep order; fetch data only when the skid is empty.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_valid ? skid_pay : in_pay;
        if (bus.flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_valid) begin
            main_load = accept;
        end else if (pop) begin
            if (skid_valid) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (accept) begin
                main_load  = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else begin
            skid_load = accept;
        end
    end

    ifid_slot #(.W(PAY_W), .RST_VAL(PAY_RST)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_d),
        .valid_o (main_valid),
        .data_o  (main_pay)
    );

    ifid_slot #(.W(PAY_W), .RST_VAL(PAY_RST)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_pay),
        .valid_o (skid_valid),
        .data_o  (skid_pay)
    );

    // Everything below is flop-derived; no handshake input reaches these outputs.
    assign bus.in_ready   = ~skid_valid;
    assign bus.out_valid  = main_valid;
    assign bus.out_opcode = main_valid ? main_pay[PAY_W-1 -: OPC_W] : NOP_OPCODE;
    assign bus.out_fields = main_pay[PC_W +: FW];
    assign bus.out_pc     = main_pay[PC_W-1:0];
    assign bus.occupancy  = {main_valid & skid_valid, main_valid ^ skid_valid};

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Scenario bench for if_id_skid_buffer: per-feature tasks plus a negedge
// scoreboard that tracks every accepted instruction until decode consumes it.
module tb_if_id_skid_buffer;
    import ifid_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    entry_t sb[$];

    if_id_skid_buffer_if bus ();

    if_id_skid_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard model: queue length is the expected occupancy, head is the expected output.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            checks++;
            if (bus.occupancy !== 2'(sb.size())) begin
                errors++;
                $display("[TB] FAIL sb_occupancy: got %0d expected %0d", bus.occupancy, sb.size());
            end
            checks++;
            if (dut.skid_valid && !dut.main_valid) begin
                errors++;
                $display("[TB] FAIL skid_implies_main: skid_valid=1 main_valid=0");
            end
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && !bus.hazard) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_pop: pc %h emitted with nothing expected", bus.out_pc);
                    end else begin
                        entry_t e;
                        e = sb.pop_front();
                        if (bus.out_opcode !== e.opcode || bus.out_fields !== e.fields || bus.out_pc !== e.pc) begin
                            errors++;
                            $display("[TB] FAIL sb_data: got op=%h f=%h pc=%h expected op=%h f=%h pc=%h",
                                     bus.out_opcode, bus.out_fields, bus.out_pc, e.opcode, e.fields, e.pc);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    entry_t n;
                    n.valid  = 1'b1;
                    n.opcode = bus.in_opcode;
                    n.fields = bus.in_fields;
                    n.pc     = bus.in_pc;
                    sb.push_back(n);
                end
            end
        end
    end

    task automatic drive_in(input logic v, input logic [15:0] pc);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_opcode = 4'($urandom_range(15));
        bus.in_fields = 12'($urandom_range(4095));
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'hA;
        bus.in_fields = 12'h5A5;
        bus.in_pc     = 16'h1234;
        bus.out_ready = 1'b0;
        bus.hazard    = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_opcode !== 4'h0 || bus.out_pc !== 16'h0 ||
                bus.out_fields !== 12'h0 || bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_state: got v=%b op=%h pc=%h f=%h rdy=%b occ=%0d expected 0,0,0,0,1,0",
                         bus.out_valid, bus.out_opcode, bus.out_pc, bus.out_fields, bus.in_ready, bus.occupancy);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_in(1'b1, 16'h0010);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL reset_first_accept: got v=%b pc=%h expected 1 0010", bus.out_valid, bus.out_pc);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        bus.hazard    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive_in(1'b1, 16'h0100 + 16'(i));
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_ready: got %b expected 1 at step %0d", bus.in_ready, i);
            end
            if (i > 0) begin
                checks++;
                if (bus.out_pc !== 16'h0100 + 16'(i - 1) || bus.occupancy !== 2'd1) begin
                    errors++;
                    $display("[TB] FAIL stream_order: got pc=%h occ=%0d expected pc=%h occ=1",
                             bus.out_pc, bus.occupancy, 16'h0100 + 16'(i - 1));
                end
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_pc !== 16'h0107 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_last: got pc=%h v=%b expected 0107 1", bus.out_pc, bus.out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_drain: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_skid();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.hazard    = 1'b0;
        drive_in(1'b1, 16'h0200);
        @(posedge clk); #1;
        drive_in(1'b1, 16'h0201);
        bus.hazard = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.hazard   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_pc !== 16'h0200) begin
            errors++;
            $display("[TB] FAIL skid_full: got occ=%0d rdy=%b pc=%h expected 2 0 0200",
                     bus.occupancy, bus.in_ready, bus.out_pc);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_pc !== 16'h0201 || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skid_second: got pc=%h occ=%0d rdy=%b expected 0201 1 1",
                     bus.out_pc, bus.occupancy, bus.in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            errors++;
            $display("[TB] FAIL skid_empty: got v=%b occ=%0d expected 0 0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_flush_full();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.hazard    = 1'b1;
        drive_in(1'b1, 16'h0210);
        @(posedge clk); #1;
        drive_in(1'b1, 16'h0211);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        drive_in(1'b1, 16'h0300);
        @(negedge clk);
        checks++;
        if (bus.occupancy !== 2'd2) begin
            errors++;
            $display("[TB] FAIL flush_prefill: got occ=%0d expected 2", bus.occupancy);
        end
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.hazard   = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_opcode !== DEF_NOP_OPCODE ||
            bus.occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_full: got v=%b op=%h occ=%0d rdy=%b expected 0 %h 0 1",
                     bus.out_valid, bus.out_opcode, bus.occupancy, bus.in_ready, DEF_NOP_OPCODE);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_ghost: got out_valid=%b pc=%h expected 0", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.hazard    = 1'b0;
        drive_in(1'b1, 16'h0400);
        @(posedge clk); #1;
        bus.flush     = 1'b1;
        bus.hazard    = 1'b1;
        bus.out_ready = 1'b1;
        drive_in(1'b1, 16'h0401);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.hazard    = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b1, 16'h0402);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            errors++;
            $display("[TB] FAIL flush_hazard: got v=%b occ=%0d expected 0 0", bus.out_valid, bus.occupancy);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_in(1'b1, 16'h0403);
        @(negedge clk);
        checks++;
        if (bus.out_pc !== 16'h0402 || bus.occupancy !== 2'd1) begin
            errors++;
            $display("[TB] FAIL simul_pre: got pc=%h occ=%0d expected 0402 1", bus.out_pc, bus.occupancy);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_pc !== 16'h0403 || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pop_accept: got pc=%h occ=%0d rdy=%b expected 0403 1 1",
                     bus.out_pc, bus.occupancy, bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] pc = 16'h1000;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            drive_in(1'($urandom_range(1)), pc);
            pc++;
            bus.out_ready = 1'($urandom_range(3) != 0);
            bus.hazard    = 1'($urandom_range(3) == 0);
            bus.flush     = 1'($urandom_range(63) == 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.hazard    = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_drain: got %0d pending v=%b expected 0 0", sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush_full();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
